// File: rtl/powerline_emulator.sv
// rtl/powerline_emulator.sv - AC-line-sync square wave generator with trim, glitch and dropout
//
// Purpose:
//   Produces the square wave an opto-isolated mains zero-crossing detector would
//   drive into a powerline trigger input. The period can be trimmed around the
//   nominal line period. Short glitches can be injected into the low phase. The
//   output can be forced low (dropout) while the period timing keeps running.
//
// Ports:
//   clk             in   1   system clock
//   rst             in   1   asynchronous reset, active high
//   enable          in   1   level; 1 = generate waveform
//   periodTrim      in   16  signed clock-count offset added to the nominal period
//   glitchRequest   in   1   strobe; inject one glitch into the current low phase
//   dropout         in   1   level; 1 = force powerline low, timing keeps running
//   powerline       out  1   emulated line-sync output (registered)
//   risingEdge      out  1   strobe on the first high cycle of each real period
//   glitchRejected  out  1   strobe; a glitchRequest could not be honoured
//   periodCount     out  16  periods started since enable, wraps at 2^16

module powerline_emulator #(
    parameter int CLK_RATE     = 100000000,
    parameter int NOMINAL_RATE = 60,
    parameter int GLITCH_USEC  = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] periodTrim,
    input  logic        glitchRequest,
    input  logic        dropout,
    output logic        powerline,
    output logic        risingEdge,
    output logic        glitchRejected,
    output logic [15:0] periodCount
);

    localparam int NOM_P = CLK_RATE / NOMINAL_RATE;
    localparam int G     = $rtoi(CLK_RATE / 1.0e6 * GLITCH_USEC);
    // Wide enough that NOM_P +/- 32768 fits as a signed value without overflow.
    localparam int CW    = $clog2(NOM_P + 32768) + 1;
    // Glitch counter holds 0..G-1.
    localparam int GW    = (G > 1) ? $clog2(G) : 1;
    localparam int P_MIN = 4 * G + 8;

    localparam logic signed [CW-1:0] NOM_P_S     = CW'(NOM_P);
    localparam logic signed [CW-1:0] P_MIN_S     = CW'(P_MIN);
    localparam logic        [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic        [CW-1:0] GLITCH_ROOM = CW'(G + 1);
    localparam logic        [GW-1:0] G_LAST      = GW'(G - 1);
    localparam logic        [GW-1:0] G_ONE       = GW'(1);

    typedef enum logic [1:0] {
        S_DISABLED,
        S_HIGH,
        S_LOW,
        S_GLITCH
    } state_t;

    state_t               state;
    logic        [CW-1:0] cnt;      // cycles left in the current phase after this one
    logic        [CW-1:0] low_len;  // low phase length of the period in flight
    logic        [GW-1:0] gcnt;     // glitch cycles left after this one

    logic signed [CW-1:0] p_sum;
    logic        [CW-1:0] p_len;
    logic        [CW-1:0] h_len;
    logic        [CW-1:0] l_len;

    // Period for a period starting at the next edge; only latched at period start.
    always_comb begin
        p_sum = NOM_P_S + $signed({{(CW-16){periodTrim[15]}}, periodTrim});
        if (p_sum < P_MIN_S) begin
            p_len = P_MIN_S;
        end else begin
            p_len = $unsigned(p_sum);
        end
        h_len = p_len >> 1;
        l_len = p_len - h_len;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_DISABLED;
            cnt            <= '0;
            low_len        <= '0;
            gcnt           <= '0;
            powerline      <= 1'b0;
            risingEdge     <= 1'b0;
            glitchRejected <= 1'b0;
            periodCount    <= '0;
        end else begin
            risingEdge     <= 1'b0;
            glitchRejected <= 1'b0;
            if (!enable) begin
                // In-flight period abandoned; periodCount holds until re-enable.
                state          <= S_DISABLED;
                powerline      <= 1'b0;
                glitchRejected <= glitchRequest;
            end else begin
                case (state)
                    S_DISABLED: begin
                        state          <= S_HIGH;
                        cnt            <= h_len - CNT_ONE;
                        low_len        <= l_len;
                        powerline      <= ~dropout;
                        risingEdge     <= ~dropout;
                        periodCount    <= 16'd1;
                        glitchRejected <= glitchRequest;
                    end
                    S_HIGH: begin
                        glitchRejected <= glitchRequest;
                        if (cnt == '0) begin
                            state     <= S_LOW;
                            cnt       <= low_len - CNT_ONE;
                            powerline <= 1'b0;
                        end else begin
                            cnt       <= cnt - CNT_ONE;
                            powerline <= ~dropout;
                        end
                    end
                    S_LOW: begin
                        if (cnt == '0) begin
                            // Period restart wins over a simultaneous glitch request.
                            state          <= S_HIGH;
                            cnt            <= h_len - CNT_ONE;
                            low_len        <= l_len;
                            powerline      <= ~dropout;
                            risingEdge     <= ~dropout;
                            periodCount    <= periodCount + 16'd1;
                            glitchRejected <= glitchRequest;
                        end else if (glitchRequest && (cnt > GLITCH_ROOM)) begin
                            // Needs G glitch cycles plus at least one low cycle after,
                            // so the glitch never merges with the next real edge.
                            state     <= S_GLITCH;
                            gcnt      <= G_LAST;
                            cnt       <= cnt - CNT_ONE;
                            powerline <= ~dropout;
                        end else begin
                            cnt            <= cnt - CNT_ONE;
                            powerline      <= 1'b0;
                            glitchRejected <= glitchRequest;
                        end
                    end
                    S_GLITCH: begin
                        // Low-phase count keeps running so the period is unchanged.
                        cnt            <= cnt - CNT_ONE;
                        glitchRejected <= glitchRequest;
                        if (gcnt == '0) begin
                            state     <= S_LOW;
                            powerline <= 1'b0;
                        end else begin
                            gcnt      <= gcnt - G_ONE;
                            powerline <= ~dropout;
                        end
                    end
                    default: begin
                        state     <= S_DISABLED;
                        powerline <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_powerline_emulator.sv
// tb/tb_powerline_emulator.sv - self-checking bench for powerline_emulator

module tb_powerline_emulator;

    localparam int CLK_RATE     = 100000;
    localparam int NOMINAL_RATE = 100;
    localparam int GLITCH_USEC  = 20;
    localparam int NOM_P        = 1000;
    localparam int G            = 2;
    localparam int P_MIN        = 4 * G + 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] periodTrim;
    logic        glitchRequest;
    logic        dropout;
    logic        powerline;
    logic        risingEdge;
    logic        glitchRejected;
    logic [15:0] periodCount;

    int n_checks  = 0;
    int n_pass    = 0;
    int cyc       = 0;
    int last_rise = -1;
    int prev_rise = -1;

    // Reference model: position within the current period, counted up from 0.
    bit m_active;
    int m_pos;
    int m_P;
    int m_H;
    int m_gend;
    int m_pc;
    bit m_pl;
    bit m_re;
    bit m_rej;

    always #5 clk = ~clk;

    powerline_emulator #(
        .CLK_RATE     (CLK_RATE),
        .NOMINAL_RATE (NOMINAL_RATE),
        .GLITCH_USEC  (GLITCH_USEC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .periodTrim     (periodTrim),
        .glitchRequest  (glitchRequest),
        .dropout        (dropout),
        .powerline      (powerline),
        .risingEdge     (risingEdge),
        .glitchRejected (glitchRejected),
        .periodCount    (periodCount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic int trim_period(input logic [15:0] t);
        int p;
        p = NOM_P + int'($signed(t));
        if (p < P_MIN) p = P_MIN;
        return p;
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_pos    = 0;
        m_P      = NOM_P;
        m_H      = NOM_P / 2;
        m_gend   = -1;
        m_pc     = 0;
        m_pl     = 1'b0;
        m_re     = 1'b0;
        m_rej    = 1'b0;
    endtask

    task automatic model_new_period();
        m_P    = trim_period(periodTrim);
        m_H    = m_P / 2;
        m_pos  = 0;
        m_gend = -1;
    endtask

    // Advance the model across one clock edge using the inputs present at that edge.
    task automatic model_edge();
        bit in_low;
        bit accept;
        m_re  = 1'b0;
        m_rej = 1'b0;
        if (!enable) begin
            m_active = 1'b0;
            m_pl     = 1'b0;
            m_rej    = glitchRequest;
        end else if (!m_active) begin
            m_active = 1'b1;
            model_new_period();
            m_pc  = 1;
            m_rej = glitchRequest;
            m_pl  = !dropout;
            m_re  = !dropout;
        end else begin
            in_low = (m_pos >= m_H) && (m_pos > m_gend);
            accept = glitchRequest && in_low && ((m_P - 1 - m_pos) >= G + 2);
            if (glitchRequest && !accept) m_rej = 1'b1;
            if (accept) m_gend = m_pos + G;
            m_pos++;
            if (m_pos == m_P) begin
                model_new_period();
                m_pc = (m_pc + 1) % 65536;
            end
            m_pl = ((m_pos < m_H) || (m_pos <= m_gend)) && !dropout;
            m_re = (m_pos == 0) && !dropout;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        chk("powerline", {31'd0, powerline}, {31'd0, m_pl});
        chk("risingEdge", {31'd0, risingEdge}, {31'd0, m_re});
        chk("glitchRejected", {31'd0, glitchRejected}, {31'd0, m_rej});
        chk("periodCount", {16'd0, periodCount}, 32'(m_pc));
        if (risingEdge === 1'b1) begin
            prev_rise = last_rise;
            last_rise = cyc;
        end
    endtask

    task automatic run_until_pos(input int target, input int budget);
        int k;
        k = 0;
        while (!(m_active && m_pos == target) && k < budget) begin
            tick();
            k++;
        end
        n_checks++;
        assert (k < budget) n_pass++;
        else $error("FAIL run_until_pos_%0d observed=timeout expected=reached", target);
    endtask

    initial begin
        int          highs;
        int          nrise;
        int          rise_before;
        logic [15:0] pc0;

        rst           = 1'b1;
        enable        = 1'b0;
        periodTrim    = 16'd0;
        glitchRequest = 1'b0;
        dropout       = 1'b0;
        model_reset();

        @(negedge clk);
        chk("reset_powerline", {31'd0, powerline}, 32'd0);
        chk("reset_risingEdge", {31'd0, risingEdge}, 32'd0);
        chk("reset_glitchRejected", {31'd0, glitchRejected}, 32'd0);
        chk("reset_periodCount", {16'd0, periodCount}, 32'd0);
        rst = 1'b0;
        repeat (3) tick();

        // Nominal 1000-clock waveform
        enable = 1'b1;
        repeat (3000) tick();
        chk("t1_count", {16'd0, periodCount}, 32'd3);
        chk("t1_interval", 32'(last_rise - prev_rise), 32'd1000);

        // Trim written mid-period applies from the next period
        repeat (200) tick();
        periodTrim = 16'd10;
        run_until_pos(0, 2000);
        chk("t2_old_period", 32'(last_rise - prev_rise), 32'd1000);
        tick();
        run_until_pos(0, 2000);
        chk("t2_trimmed_period", 32'(last_rise - prev_rise), 32'd1010);
        chk("t2_count", {16'd0, periodCount}, 32'd6);

        // Most negative trim clamps to the minimum period
        periodTrim = 16'h8000;
        tick();
        run_until_pos(0, 2000);
        tick();
        run_until_pos(0, 100);
        chk("t2_clamp_period", 32'(last_rise - prev_rise), 32'd16);
        periodTrim = 16'd0;
        tick();
        run_until_pos(0, 100);

        // Glitch 100 clocks into the low phase
        run_until_pos(600, 2000);
        rise_before   = last_rise;
        glitchRequest = 1'b1;
        tick();
        glitchRequest = 1'b0;
        highs = (powerline === 1'b1) ? 1 : 0;
        repeat (398) begin
            tick();
            if (powerline === 1'b1) highs++;
        end
        chk("t3_glitch_width", 32'(highs), 32'd2);
        chk("t3_no_rise_in_low", 32'(last_rise), 32'(rise_before));
        tick();
        chk("t3_period_kept", 32'(last_rise - prev_rise), 32'd1000);

        // Rejections: during HIGH, too late in LOW, and on LOW expiry
        run_until_pos(100, 2000);
        glitchRequest = 1'b1;
        tick();
        glitchRequest = 1'b0;
        chk("t4_rej_high", {31'd0, glitchRejected}, 32'd1);
        run_until_pos(997, 2000);
        glitchRequest = 1'b1;
        tick();
        glitchRequest = 1'b0;
        chk("t4_rej_late", {31'd0, glitchRejected}, 32'd1);
        chk("t4_late_no_pulse", {31'd0, powerline}, 32'd0);
        tick();
        glitchRequest = 1'b1;
        tick();
        glitchRequest = 1'b0;
        chk("t4_rej_expiry", {31'd0, glitchRejected}, 32'd1);
        chk("t4_expiry_rise", {31'd0, risingEdge}, 32'd1);
        run_until_pos(995, 2000);
        glitchRequest = 1'b1;
        tick();
        glitchRequest = 1'b0;
        chk("t4_last_accept", {31'd0, glitchRejected}, 32'd0);
        chk("t4_last_accept_pulse", {31'd0, powerline}, 32'd1);

        // Dropout for 3000 clocks keeps timing running
        run_until_pos(500, 2000);
        pc0         = periodCount;
        rise_before = last_rise;
        dropout     = 1'b1;
        nrise       = 0;
        highs       = 0;
        repeat (3000) begin
            tick();
            if (risingEdge === 1'b1) nrise++;
            if (powerline === 1'b1) highs++;
        end
        dropout = 1'b0;
        chk("t5_no_rise", 32'(nrise), 32'd0);
        chk("t5_held_low", 32'(highs), 32'd0);
        chk("t5_count", {16'd0, periodCount}, {16'd0, 16'(pc0 + 16'd3)});
        run_until_pos(0, 2000);
        chk("t5_grid", 32'(last_rise - rise_before), 32'd4000);

        // Randomised traffic
        for (int i = 0; i < 12000; i++) begin
            glitchRequest = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 499) == 0) periodTrim = 16'($urandom_range(0, 600)) - 16'd300;
            if ($urandom_range(0, 1499) == 0) periodTrim = 16'h8000 + 16'($urandom_range(0, 32000));
            if ($urandom_range(0, 699) == 0) dropout = ~dropout;
            enable = ($urandom_range(0, 2999) != 0);
            tick();
        end

        // Disable mid-HIGH, re-enable, async reset mid-LOW
        periodTrim    = 16'd0;
        dropout       = 1'b0;
        enable        = 1'b1;
        glitchRequest = 1'b0;
        tick();
        run_until_pos(100, 3000);
        enable = 1'b0;
        tick();
        chk("t6_disable_low", {31'd0, powerline}, 32'd0);
        repeat (5) tick();
        enable = 1'b1;
        tick();
        chk("t6_restart_count", {16'd0, periodCount}, 32'd1);
        chk("t6_restart_rise", {31'd0, risingEdge}, 32'd1);
        run_until_pos(600, 2000);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("t6_rst_powerline", {31'd0, powerline}, 32'd0);
        chk("t6_rst_risingEdge", {31'd0, risingEdge}, 32'd0);
        chk("t6_rst_glitchRejected", {31'd0, glitchRejected}, 32'd0);
        chk("t6_rst_periodCount", {16'd0, periodCount}, 32'd0);
        #1;
        rst = 1'b0;
        repeat (20) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
